// File: rtl/glyph_string_draw.sv
// rtl/glyph_string_draw.sv - erase-then-draw glyph string renderer for the VGA pixel port
// Optional SKIP_BLANK_EN: all-zero glyphs are stepped over in one cycle.
module glyph_string_draw #(
  parameter int GLYPH_W    = 12,
  parameter int GLYPH_H    = 12,
  parameter int NUM_GLYPHS = 3,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int COLOUR_W   = 3
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [NUM_GLYPHS*GLYPH_W*GLYPH_H-1:0]   glyphs,
  input  logic [X_W-1:0]                          x,
  input  logic [Y_W-1:0]                          y,
  input  logic [COLOUR_W-1:0]                     colour_in,
  output logic [X_W-1:0]                          x_out,
  output logic [Y_W-1:0]                          y_out,
  output logic [COLOUR_W-1:0]                     colour,
  output logic                                    writeEn,
  output logic                                    busy,
  output logic                                    done
);

  localparam int P     = GLYPH_W * GLYPH_H;
  localparam int BITS  = NUM_GLYPHS * P;
  localparam int G_W   = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1;
  localparam int PIX_W = (P > 1) ? $clog2(P) : 1;
  localparam int ROW_W = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int COL_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DRAW, S_DONE} state_t;
  state_t r_state, w_next;

  logic [BITS-1:0]     r_new_bits, r_old_bits;
  logic [X_W-1:0]      r_new_x, r_old_x;
  logic [Y_W-1:0]      r_new_y, r_old_y;
  logic [COLOUR_W-1:0] r_new_colour;
  logic                r_drawn_valid;

  logic [G_W-1:0]      r_g;
  logic [PIX_W-1:0]    r_pix;
  logic [ROW_W-1:0]    r_row;
  logic [COL_W-1:0]    r_col;

  logic [X_W-1:0]      r_x_out;
  logic [Y_W-1:0]      r_y_out;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_we, r_busy, r_done;

  logic [BITS-1:0]     w_bits;
  logic [P-1:0]        w_glyph;
  logic [X_W-1:0]      w_ox, w_x;
  logic [Y_W-1:0]      w_oy, w_y;
  logic [COLOUR_W-1:0] w_pcolour;
  logic                w_bit, w_active, w_glyph_end, w_pass_end;
  logic                w_we_d, w_busy_d, w_done_d;

  // The CLEAR pass replays the previous string from the old shadow in colour 0.
  always_comb begin
    w_bits    = (r_state == S_CLEAR) ? r_old_bits : r_new_bits;
    w_ox      = (r_state == S_CLEAR) ? r_old_x    : r_new_x;
    w_oy      = (r_state == S_CLEAR) ? r_old_y    : r_new_y;
    w_pcolour = (r_state == S_CLEAR) ? '0         : r_new_colour;
    w_glyph   = '0;
    for (int g = 0; g < NUM_GLYPHS; g++) begin
      if (r_g == G_W'(g)) w_glyph = w_bits[g*P +: P];
    end
    w_bit    = w_glyph[PIX_W'(P-1) - r_pix];
    w_x      = w_ox + X_W'(r_g * GLYPH_W) + X_W'(r_col);
    w_y      = w_oy + Y_W'(r_row);
    w_active = (r_state == S_CLEAR) || (r_state == S_DRAW);
`ifdef SKIP_BLANK_EN
    w_glyph_end = (r_pix == PIX_W'(P-1)) || ~|w_glyph;
`else
    w_glyph_end = (r_pix == PIX_W'(P-1));
`endif
    w_pass_end = w_glyph_end && (r_g == G_W'(NUM_GLYPHS-1));
  end

  always_comb begin
    w_next   = r_state;
    w_we_d   = 1'b0;
    w_busy_d = 1'b0;
    w_done_d = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = r_drawn_valid ? S_CLEAR : S_DRAW;
      end
      S_CLEAR: begin
        w_we_d   = w_bit;
        w_busy_d = 1'b1;
        if (w_pass_end) w_next = S_DRAW;
      end
      S_DRAW: begin
        w_we_d   = w_bit;
        w_busy_d = 1'b1;
        if (w_pass_end) w_next = S_DONE;
      end
      S_DONE: begin
        w_done_d = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x_out       <= '0;
      r_y_out       <= '0;
      r_colour      <= '0;
      r_we          <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_drawn_valid <= 1'b0;
      r_g           <= '0;
      r_pix         <= '0;
      r_row         <= '0;
      r_col         <= '0;
    end else begin
      r_we   <= w_we_d;
      r_busy <= w_busy_d;
      r_done <= w_done_d;
      if (w_active) begin
        r_x_out  <= w_x;
        r_y_out  <= w_y;
        r_colour <= w_pcolour;
      end
      if (r_state == S_IDLE && start) begin
        r_new_bits   <= glyphs;
        r_new_x      <= x;
        r_new_y      <= y;
        r_new_colour <= colour_in;
      end
      if (r_state == S_DRAW && w_pass_end) begin
        r_old_bits    <= r_new_bits;
        r_old_x       <= r_new_x;
        r_old_y       <= r_new_y;
        r_drawn_valid <= 1'b1;
      end
      // Scan counters: column fastest, then row, then glyph.
      if (w_active && !w_glyph_end) begin
        r_pix <= r_pix + 1'b1;
        if (r_col == COL_W'(GLYPH_W-1)) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end else begin
        r_pix <= '0;
        r_row <= '0;
        r_col <= '0;
        if (w_active && !w_pass_end) r_g <= r_g + 1'b1;
        else                         r_g <= '0;
      end
    end
  end

  assign x_out   = r_x_out;
  assign y_out   = r_y_out;
  assign colour  = r_colour;
  assign writeEn = r_we;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_glyph_string_draw.sv
// tb/tb_glyph_string_draw.sv - table-driven check of glyph_string_draw
module tb_glyph_string_draw;

  localparam int W = 12, H = 12, N = 3, P = W*H, BITS = N*P;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [BITS-1:0] glyphs = '0;
  logic [7:0]      x = '0;
  logic [6:0]      y = '0;
  logic [2:0]      colour_in = '0;
  logic [7:0]      x_out;
  logic [6:0]      y_out;
  logic [2:0]      colour;
  logic            writeEn, busy, done;

  glyph_string_draw dut (
    .clk(clk), .reset(reset), .start(start), .glyphs(glyphs),
    .x(x), .y(y), .colour_in(colour_in),
    .x_out(x_out), .y_out(y_out), .colour(colour),
    .writeEn(writeEn), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int pass_len(input int nonblank);
`ifdef SKIP_BLANK_EN
    return nonblank * P + (N - nonblank);
`else
    return N * P + 0 * nonblank;
`endif
  endfunction

  function automatic logic [BITS-1:0] one_bit(input int g, input int r, input int c);
    logic [BITS-1:0] v;
    v = '0;
    v[(g+1)*P - 1 - (r*W + c)] = 1'b1;
    return v;
  endfunction

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    int         g, r, col;
    bit         clr;
    int         nw;
    int         w0, w1;   // packed {x,y,colour}
    int         mid;
  } vec_t;

  vec_t vecs[4];

  int first_busy, busy_cnt, done_cnt, nw, bad;
  int wr[4];

  task automatic run(input logic [7:0] vx, input logic [6:0] vy, input logic [2:0] vc,
                     input logic [BITS-1:0] vg, input int mid);
    first_busy = -1; busy_cnt = 0; done_cnt = 0; nw = 0; bad = 0;
    @(negedge clk);
    x = vx; y = vy; colour_in = vc; glyphs = vg; start = 1'b1;
    for (int i = 1; i < 3000; i++) begin
      @(negedge clk);
      start = (i == mid);
      if (i == 1) begin
        x = 8'($urandom); y = 7'($urandom); colour_in = 3'($urandom);
        glyphs = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom};
      end
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = i;
      end
      if (writeEn) begin
        if (nw < 4) wr[nw] = {x_out, y_out, colour};
        nw++;
        if (!busy) bad++;
      end
      if (done) begin
        done_cnt++;
        if (busy) bad++;
        break;
      end
    end
    start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (busy || writeEn || done) bad++;
    end
  endtask

  initial begin
    vecs[0] = '{8'd10,  7'd20,  3'd4, 0, 0,  0,  1'b0, 1, {8'd10, 7'd20, 3'd4},  0,                     0};
    vecs[1] = '{8'd40,  7'd5,   3'd2, 2, 11, 11, 1'b1, 2, {8'd10, 7'd20, 3'd0},  {8'd75, 7'd16, 3'd2},  100};
    vecs[2] = '{8'd250, 7'd100, 3'd7, 1, 0,  0,  1'b1, 2, {8'd75, 7'd16, 3'd0},  {8'd6, 7'd100, 3'd7},  0};
    vecs[3] = '{8'd0,   7'd125, 3'd1, 0, 5,  3,  1'b1, 2, {8'd6, 7'd100, 3'd0},  {8'd3, 7'd2, 3'd1},    0};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_writeEn", int'(writeEn), 0);
    chk("rst_busy",    int'(busy),    0);
    chk("rst_done",    int'(done),    0);
    chk("rst_x_out",   int'(x_out),   0);
    chk("rst_y_out",   int'(y_out),   0);
    chk("rst_colour",  int'(colour),  0);

    for (int i = 0; i < 4; i++) begin
      run(vecs[i].x, vecs[i].y, vecs[i].c, one_bit(vecs[i].g, vecs[i].r, vecs[i].col), vecs[i].mid);
      chk($sformatf("v%0d_first_busy", i), first_busy, 2);
      chk($sformatf("v%0d_busy_cycles", i), busy_cnt, (vecs[i].clr ? 2 : 1) * pass_len(1));
      chk($sformatf("v%0d_done", i), done_cnt, 1);
      chk($sformatf("v%0d_writes", i), nw, vecs[i].nw);
      chk($sformatf("v%0d_w0", i), wr[0], vecs[i].w0);
      if (vecs[i].nw > 1) chk($sformatf("v%0d_w1", i), wr[1], vecs[i].w1);
      chk($sformatf("v%0d_protocol", i), bad, 0);
    end

    // Reset mid-DRAW, coinciding with a start request that must lose.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    x = 8'd1; y = 7'd1; colour_in = 3'd5; glyphs = one_bit(0, 0, 0); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (59) @(negedge clk);
    chk("mid_busy_before_reset", int'(busy), 1);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("mid_rst_writeEn", int'(writeEn), 0);
    chk("mid_rst_busy",    int'(busy),    0);
    chk("mid_rst_x_out",   int'(x_out),   0);
    repeat (3) @(negedge clk);
    chk("mid_rst_start_lost", int'(busy), 0);

    // All-blank string after that reset: no CLEAR pass.
    run(8'd20, 7'd30, 3'd6, '0, 0);
    chk("blank_first_busy", first_busy, 2);
    chk("blank_busy_cycles", busy_cnt, pass_len(0));
    chk("blank_done", done_cnt, 1);
    chk("blank_writes", nw, 0);
    chk("blank_protocol", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
